// File: rtl/snoop_responder.sv
// snoop_responder: services coherence snoops for a 2-way dcache.
// A snoop is accepted in IDLE when ccwait and cache_idle are both high. The
// tag arrays are then looked up once. A dirty hit writes the two-word block
// back over the data port and raises ccwrite. Every snoop ends with a
// one-cycle UPDATE (tag-state write, link clear) and then waits in DONE for
// ccwait to drop.
// Optional build macro SNOOP_STATS_EN adds saturating hit/writeback counters.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   ccwait, ccinv, ccsnoopaddr snoop request, invalidate qualifier, address
//   dwait                     data-port wait (low = word accepted)
//   cache_idle                dcache FSM idle, snoop may start
//   wayN_tag/valid/dirty      tag-array read data for set snoop_idx
//   wayN_word0/word1          data-array words for set snoop_idx
//   link_valid, link_addr     LL/SC link register
//   snoop_idx                 set index to the arrays
//   ccwrite                   dirty hit, cache-to-cache transfer follows
//   dWEN, daddr, dstore       writeback port
//   upd_en/way/valid/dirty    one-cycle tag-state write
//   snoop_busy, link_clr      dcache stall, link-register clear pulse
//   snoop_hits, snoop_wbs     statistics counters (SNOOP_STATS_EN only)
module snoop_responder (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  input  logic        dwait,
  input  logic        cache_idle,
  input  logic [25:0] way0_tag,
  input  logic [25:0] way1_tag,
  input  logic        way0_valid,
  input  logic        way1_valid,
  input  logic        way0_dirty,
  input  logic        way1_dirty,
  input  logic [31:0] way0_word0,
  input  logic [31:0] way0_word1,
  input  logic [31:0] way1_word0,
  input  logic [31:0] way1_word1,
  input  logic        link_valid,
  input  logic [31:0] link_addr,
  output logic [2:0]  snoop_idx,
  output logic        ccwrite,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        upd_en,
  output logic        upd_way,
  output logic        upd_valid,
  output logic        upd_dirty,
  output logic        snoop_busy,
  output logic        link_clr
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0] snoop_hits,
  output logic [15:0] snoop_wbs
`endif
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB0, WB1, UPDATE, DONE} state_t;
  state_t state;
  logic [31:0] saddr;
  logic sinv, shit, sway;
  logic h0, h1, hit, hway, hdirty;
  logic unused_bits;
  assign h0 = way0_valid && way0_tag == saddr[31:6];
  assign h1 = way1_valid && way1_tag == saddr[31:6];
  assign hit = h0 | h1;
  // way0 wins when both ways match
  assign hway = !h0;
  assign hdirty = h0 ? way0_dirty : way1_dirty;
  // in IDLE the arrays are pointed at the incoming address so data is ready
  assign snoop_idx = state == IDLE ? ccsnoopaddr[5:3] : saddr[5:3];
  assign snoop_busy = state != IDLE;
  assign ccwrite = (state == LOOKUP && hit && hdirty) || state == WB0 || state == WB1;
  assign upd_en = state == UPDATE && shit;
  assign upd_way = upd_en & sway;
  assign upd_valid = upd_en & !sinv;
  assign upd_dirty = 1'b0;
  // link is cleared on a matching invalidate even when the snoop missed
  assign link_clr = state == UPDATE && sinv && link_valid && link_addr[31:2] == saddr[31:2];
  assign unused_bits = ^{link_addr[1:0], saddr[2:0]};
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      saddr <= '0;
      sinv <= 1'b0;
      shit <= 1'b0;
      sway <= 1'b0;
      dWEN <= 1'b0;
      daddr <= '0;
      dstore <= '0;
    end else begin
      case (state)
        IDLE: if (ccwait && cache_idle) begin
          state <= LOOKUP;
          saddr <= ccsnoopaddr;
          sinv <= ccinv;
        end
        LOOKUP: begin
          shit <= hit;
          sway <= hway;
          if (hit && hdirty) begin
            state <= WB0;
            dWEN <= 1'b1;
            daddr <= {saddr[31:3], 3'b000};
            dstore <= hway ? way1_word0 : way0_word0;
          end else begin
            state <= UPDATE;
          end
        end
        WB0: if (!dwait) begin
          state <= WB1;
          daddr[2] <= 1'b1;
          dstore <= sway ? way1_word1 : way0_word1;
        end
        WB1: if (!dwait) begin
          state <= UPDATE;
          dWEN <= 1'b0;
          daddr <= '0;
          dstore <= '0;
        end
        UPDATE: state <= DONE;
        DONE: if (!ccwait) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SNOOP_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_hits <= '0;
      snoop_wbs <= '0;
    end else begin
      if (state == LOOKUP && hit && snoop_hits != 16'hFFFF) snoop_hits <= snoop_hits + 16'd1;
      if (state == WB1 && !dwait && snoop_wbs != 16'hFFFF) snoop_wbs <= snoop_wbs + 16'd1;
    end
  end
`endif
endmodule
